demux8_deserializer: RTL and testbench



---
 rtl/demux_pkg.sv | 15 +
 rtl/dec3to8.sv | 13 +
 rtl/demux8_deserializer.sv | 63 ++++++
 tb/tb_demux8_deserializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared widths and slot-index helper for the 1-to-8 serial demultiplexer.
package demux_pkg;
  localparam int SEL_W   = 3;
  localparam int N_SLOTS = 8;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [N_SLOTS-1:0] word_t;

  localparam sel_t LAST_SEL = sel_t'(N_SLOTS - 1);

  // Map a stream position to a word slot: identity for LSB-first, mirrored otherwise.
  function automatic sel_t slot_of(input sel_t sel, input logic lsb_first);
    return lsb_first ? sel : sel_t'(LAST_SEL - sel);
  endfunction
endpackage

// File: rtl/dec3to8.sv
// Gated 3-to-8 one-hot decoder producing per-slot write enables.
module dec3to8
  import demux_pkg::*;
(
  input  logic  en_i,
  input  sel_t  idx_i,
  output word_t we_o
);
  always_comb begin
    we_o = '0;
    if (en_i) we_o[idx_i] = 1'b1;
  end
endmodule

// File: rtl/demux8_deserializer.sv
// Serial-to-8-bit deserializer: bits steered into slots by a select counter; the
// completed word is held in a one-entry valid/ready buffer, stalling only the completing bit.
module demux8_deserializer
  import demux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i,
  input  logic  i_valid,
  output logic  i_ready,
  input  logic  sync,
  output sel_t  s,
  output word_t o,
  output logic  o_valid,
  input  logic  o_ready
);
  sel_t  s_q, s_d, sel_base;
  word_t shadow_q, shadow_d, shadow_base, shadow_wr, slot_we;
  word_t o_q, o_d;
  logic  o_valid_q, o_valid_d;
  logic  accept, complete;

  assign i_ready = !((s_q == LAST_SEL) && o_valid_q && !o_ready);
  assign accept  = i_valid && i_ready;

  dec3to8 u_dec (
    .en_i  (accept),
    .idx_i (slot_of(sel_base, LSB_FIRST)),
    .we_o  (slot_we)
  );

  // sync restarts the word in the same cycle, so an accepted bit lands in slot 0.
  always_comb begin
    sel_base    = sync ? '0 : s_q;
    shadow_base = sync ? '0 : shadow_q;
    shadow_wr   = (shadow_base & ~slot_we) | (slot_we & {N_SLOTS{i}});
    complete    = accept && !sync && (s_q == LAST_SEL);
    s_d         = accept ? sel_t'(sel_base + sel_t'(1)) : sel_base;
    shadow_d    = complete ? '0 : shadow_wr;
    o_d         = complete ? shadow_wr : o_q;
    o_valid_d   = complete || (o_valid_q && !o_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      shadow_q  <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      shadow_q  <= shadow_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign s       = s_q;
  assign o       = o_q;
  assign o_valid = o_valid_q;
endmodule

// File: tb/tb_demux8_deserializer.sv
// Directed bench for demux8_deserializer: LSB-first and MSB-first instances share stimulus.
module tb_demux8_deserializer;
  import demux_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n, d, d_vld, sync, o_ready;
  logic  ir_l, ov_l, ir_m, ov_m;
  sel_t  s_l, s_m;
  word_t o_l, o_m;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  demux8_deserializer #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .i(d), .i_valid(d_vld), .i_ready(ir_l), .sync(sync),
    .s(s_l), .o(o_l), .o_valid(ov_l), .o_ready(o_ready)
  );
  demux8_deserializer #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .i(d), .i_valid(d_vld), .i_ready(ir_m), .sync(sync),
    .s(s_m), .o(o_m), .o_valid(ov_m), .o_ready(o_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each handshake that will consume a word at the next edge is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ov_l && o_ready) begin
      chk("sb_word_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) chk("sb_word", o_l, sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    logic ok;
    ok = 1'b0;
    d = b; d_vld = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = ir_l;
    end
    if (!ok) chk("accept_timeout", ir_l, 1);
    step();
    d_vld = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    sb.push_back(w);
    for (int k = 0; k < 8; k++) send_bit(w[k]);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; d = 1'b0; d_vld = 1'b0; sync = 1'b0; o_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_s", s_l, 0);
    chk("rst_o", o_l, 8'h00);
    chk("rst_o_valid", ov_l, 0);
    chk("rst_i_ready", ir_l, 1);
    step();

    // LSB-first basic word, s stepping 0..7 then 0, o_valid for exactly one cycle
    pat = 8'b0100_1101;
    sb.push_back(8'h4D);
    for (int k = 0; k < 8; k++) begin
      d = pat[k]; d_vld = 1'b1;
      @(negedge clk);
      chk("seq_s", s_l, k);
      step();
    end
    d_vld = 1'b0;
    @(negedge clk);
    chk("basic_o_valid", ov_l, 1);
    chk("basic_s_wrap", s_l, 0);
    chk("msb_o", o_m, 8'hB2);
    chk("msb_o_valid", ov_m, 1);
    step();
    @(negedge clk);
    chk("basic_one_cycle", ov_l, 0);
    step();

    // MSB-first instance on the same bit sequence
    send_word(8'h4D);
    @(negedge clk);
    chk("msb2_o", o_m, 8'hB2);
    step(); step();

    // Backpressure: hold A5, then stall the completing bit of 3C
    o_ready = 1'b0;
    send_word(8'hA5);
    pat = 8'h3C;
    for (int k = 0; k < 7; k++) send_bit(pat[k]);
    d = pat[7]; d_vld = 1'b1;
    @(negedge clk);
    chk("bp_s7", s_l, 7);
    chk("bp_i_ready_low", ir_l, 0);
    chk("bp_hold_o", o_l, 8'hA5);
    step();
    @(negedge clk);
    chk("bp_still_stalled", ir_l, 0);
    chk("bp_s_held", s_l, 7);
    chk("bp_o_stable", o_l, 8'hA5);
    step();
    sb.push_back(8'h3C);
    o_ready = 1'b1;
    @(negedge clk);
    chk("bp_i_ready_high", ir_l, 1);
    step();
    o_ready = 1'b0; d_vld = 1'b0;
    @(negedge clk);
    chk("bp_reload_valid", ov_l, 1);
    chk("bp_reload_o", o_l, 8'h3C);
    step();
    o_ready = 1'b1;
    step(); step();

    // sync mid-word: restart with the sync-cycle bit as slot 0
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    sync = 1'b1; d = 1'b1; d_vld = 1'b1;
    step();
    sync = 1'b0; d_vld = 1'b0;
    @(negedge clk);
    chk("sync_s", s_l, 1);
    chk("sync_no_word", ov_l, 0);
    step();
    sb.push_back(8'h01);
    for (int k = 0; k < 7; k++) send_bit(1'b0);
    step(); step();

    // Gapped input: s holds during bubbles, completion after 15 cycles
    pat = 8'h96;
    sb.push_back(pat);
    for (int k = 0; k < 8; k++) begin
      d = pat[k]; d_vld = 1'b1;
      step();
      d_vld = 1'b0;
      if (k < 7) begin
        @(negedge clk);
        chk("gap_s_hold", s_l, k + 1);
        chk("gap_no_valid", ov_l, 0);
        step();
      end
    end
    @(negedge clk);
    chk("gap_done", ov_l, 1);
    step(); step();

    // Asynchronous reset mid-word with a word pending
    o_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(k[0]);
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    @(negedge clk);
    chk("pre_rst_valid", ov_l, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", ov_l, 0);
    chk("arst_s", s_l, 0);
    chk("arst_o", o_l, 8'h00);
    step();
    rst_n = 1'b1;
    o_ready = 1'b1;
    send_word(8'hC3);
    step(); step();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
